gate_truth_table_checker: RTL and testbench

- Sequential stimulus/checker stage placed directly upstream of a 2-input combinational gate (AND/OR/XOR/NAND etc.) from the basic gate library.
- Drives the gate's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector.
- Samples the gate output and compares it against an expected 4-bit truth table.
- Reports per-vector mismatches and an overall pass flag; used for lab bring-up and self-test of gate instances.

---
 rtl/gate_truth_table_checker.sv | 124 ++++++++++++
 tb/tb_gate_truth_table_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// ============================================================================
// gate_truth_table_checker - sweeps a 2-input gate through all four vectors
// and checks each sampled output against a latched 4-bit truth table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_truth_table_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] truth_table,
   input  logic       gate_out,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [1:0] idx_q;
   logic [3:0] cnt_q;
   logic [3:0] tt_q;
   logic       a_q;
   logic       b_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] fail_mask_q;
   logic [3:0] fail_mask_d;

   // Mask including the compare of the current SAMPLE cycle, so the final
   // vector's result is already visible when pass is decided.
   always_comb begin
      fail_mask_d = fail_mask_q;
      if (state_q == ST_SAMPLE && gate_out != tt_q[idx_q]) begin
         fail_mask_d[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= 4'd0;
         tt_q        <= 4'd0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               a_q    <= 1'b0;
               b_q    <= 1'b0;
               if (start) begin
                  tt_q        <= truth_table;
                  fail_mask_q <= 4'd0;
                  pass_q      <= 1'b0;
                  idx_q       <= 2'd0;
                  cnt_q       <= 4'd0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               fail_mask_q <= fail_mask_d;
               if (idx_q == 2'd3) begin
                  done_q  <= 1'b1;
                  pass_q  <= (fail_mask_d == 4'd0);
                  state_q <= ST_DONE;
               end else begin
                  idx_q        <= idx_q + 2'd1;
                  {a_q, b_q}   <= idx_q + 2'd1;
                  cnt_q        <= 4'd0;
                  state_q      <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               a_q     <= 1'b0;
               b_q     <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_checker.sv
// ============================================================================
// tb_gate_truth_table_checker - directed sweeps on three settle-time variants
// with a queue of expected pass/fail_mask results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_truth_table_checker;

   localparam int G_AND = 0;
   localparam int G_XOR = 1;
   localparam int G_ST0 = 2;
   localparam int G_ST1 = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start     [3];
   logic [3:0] tt        [3];
   logic       gout      [3];
   logic       a_o       [3];
   logic       b_o       [3];
   logic       busy_o    [3];
   logic       done_o    [3];
   logic       pass_o    [3];
   logic [3:0] mask_o    [3];
   int         gmode;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         d;
      logic       pass;
      logic [3:0] mask;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   gate_truth_table_checker #(.SETTLE_CYCLES(2)) u_dut_s2 (
      .clk(clk), .reset(reset), .start(start[0]), .truth_table(tt[0]),
      .gate_out(gout[0]), .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .pass(pass_o[0]), .fail_mask(mask_o[0]));

   gate_truth_table_checker #(.SETTLE_CYCLES(1)) u_dut_s1 (
      .clk(clk), .reset(reset), .start(start[1]), .truth_table(tt[1]),
      .gate_out(gout[1]), .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .pass(pass_o[1]), .fail_mask(mask_o[1]));

   gate_truth_table_checker #(.SETTLE_CYCLES(15)) u_dut_s15 (
      .clk(clk), .reset(reset), .start(start[2]), .truth_table(tt[2]),
      .gate_out(gout[2]), .a(a_o[2]), .b(b_o[2]), .busy(busy_o[2]),
      .done(done_o[2]), .pass(pass_o[2]), .fail_mask(mask_o[2]));

   function automatic logic gfun(input int m, input logic ga, input logic gb);
      case (m)
         G_AND:   return ga & gb;
         G_XOR:   return ga ^ gb;
         G_ST0:   return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int s_of(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         gout[i] = gfun(gmode, a_o[i], b_o[i]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sweep on DUT d: optional stray start pulses, optional reset at cycle rst_at.
   task automatic run_sweep(input int d, input logic [3:0] ttv, input int gm,
                            input bit inj, input int rst_at);
      int         s;
      int         len;
      int         dones;
      logic [1:0] kk;
      logic [3:0] m;
      exp_t       e;
      exp_t       got;
      s     = s_of(d);
      len   = 4 * (s + 1) + 1;
      gmode = gm;
      m     = 4'd0;
      for (int k = 0; k < 4; k++) begin
         kk = 2'(k);
         if (gfun(gm, kk[1], kk[0]) !== ttv[k]) m[k] = 1'b1;
      end
      e.d    = d;
      e.pass = (m == 4'd0);
      e.mask = m;
      got    = e;

      @(negedge clk);
      tt[d]    = ttv;
      start[d] = 1'b1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      start[d] = 1'b0;

      for (int c = 1; c <= len; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (rst_at != 0 && c == rst_at + 1) begin
            chk("rst_a",    32'(a_o[d]),    32'd0);
            chk("rst_b",    32'(b_o[d]),    32'd0);
            chk("rst_busy", 32'(busy_o[d]), 32'd0);
            chk("rst_done", 32'(done_o[d]), 32'd0);
            chk("rst_pass", 32'(pass_o[d]), 32'd0);
            chk("rst_mask", 32'(mask_o[d]), 32'd0);
            reset = 1'b0;
            if (sbq.size() > 0) void'(sbq.pop_front());
            dones = 0;
            for (int j = 0; j < 2 * len; j++) begin
               @(posedge clk);
               #1;
               if (done_o[d] === 1'b1) dones++;
            end
            chk("rst_no_done", 32'(dones), 32'd0);
            return;
         end
         chk("busy", 32'(busy_o[d]), 32'd1);
         chk("done", 32'(done_o[d]), 32'(c == len));
         if (c < len) begin
            chk("ab_vec", 32'({a_o[d], b_o[d]}), 32'((c - 1) / (s + 1)));
         end
         if (c == 2) tt[d] = ~ttv;
         if (c == len) begin
            chk("sb_pending", 32'(sbq.size()), 32'd1);
            if (done_o[d] === 1'b1 && sbq.size() > 0) begin
               got = sbq.pop_front();
               chk("pass",      32'(pass_o[d]), 32'(got.pass));
               chk("fail_mask", 32'(mask_o[d]), 32'(got.mask));
            end
         end
         start[d] = inj && (c == 3 || c == 12);
         if (c == rst_at) reset = 1'b1;
      end
      start[d] = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_busy",  32'(busy_o[d]), 32'd0);
      chk("idle_done",  32'(done_o[d]), 32'd0);
      chk("idle_ab",    32'({a_o[d], b_o[d]}), 32'd0);
      chk("hold_pass",  32'(pass_o[d]), 32'(got.pass));
      chk("hold_mask",  32'(mask_o[d]), 32'(got.mask));
   endtask

   initial begin
      reset = 1'b1;
      gmode = G_AND;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         tt[i]    = 4'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_ab",   32'({a_o[i], b_o[i]}), 32'd0);
         chk("reset_busy", 32'(busy_o[i]), 32'd0);
         chk("reset_done", 32'(done_o[i]), 32'd0);
         chk("reset_pass", 32'(pass_o[i]), 32'd0);
         chk("reset_mask", 32'(mask_o[i]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      run_sweep(0, 4'b1000, G_AND, 1'b0, 0);
      run_sweep(0, 4'b0110, G_XOR, 1'b0, 0);
      run_sweep(0, 4'b1001, G_XOR, 1'b0, 0);
      run_sweep(0, 4'b0111, G_ST0, 1'b0, 0);
      run_sweep(0, 4'b0111, G_ST1, 1'b0, 0);
      run_sweep(0, 4'b1000, G_AND, 1'b1, 0);
      run_sweep(0, 4'b0110, G_XOR, 1'b0, 6);
      run_sweep(0, 4'b0110, G_XOR, 1'b0, 0);
      run_sweep(1, 4'b1000, G_AND, 1'b0, 0);
      run_sweep(1, 4'b0111, G_ST0, 1'b0, 0);
      run_sweep(2, 4'b1000, G_AND, 1'b0, 0);
      run_sweep(2, 4'b0111, G_ST1, 1'b0, 0);

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
